// File: rtl/kd_gain_adjust.sv
// kd_gain_adjust: debounced inc/dec pushbuttons to a saturated Kd gain with auto-repeat.
// Optional KD_GAIN_COARSE_STEP_EN adds step_coarse (step size STEP*16).
module kd_gain_adjust #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int GAIN_INIT       = 100,
  parameter int GAIN_MIN        = 0,
  parameter int GAIN_MAX        = 65535,
  parameter int STEP            = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_inc_n,
  input  logic        btn_dec_n,
`ifdef KD_GAIN_COARSE_STEP_EN
  input  logic        step_coarse,
`endif
  output logic [15:0] gain_out,
  output logic        gain_changed
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] T_DELAY = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] T_RATE  = TW'(REPEAT_RATE - 1);
  localparam logic [16:0]   G_MIN   = 17'(GAIN_MIN);
  localparam logic [16:0]   G_MAX   = 17'(GAIN_MAX);
  localparam logic [15:0]   G_INIT  = 16'(GAIN_INIT);
  localparam logic [16:0]   FINE    = 17'(STEP);
  localparam logic [16:0]   COARSE  = 17'(STEP * 16);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} state_t;

  logic [1:0]    raw, s1, s2, db, fall, blk, warm, lvl;
  logic [CW-1:0] cnt [2];

  assign raw = {btn_dec_n, btn_inc_n};
  assign lvl = ~db & ~blk;

  // blk masks a button that was already held when reset released
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= '1;
      s2   <= '1;
      db   <= '1;
      fall <= '0;
      blk  <= '1;
      warm <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      warm <= {warm[0], 1'b1};
      for (int i = 0; i < 2; i++) begin
        fall[i] <= 1'b0;
        if (warm[1] && s2[i] && db[i]) blk[i] <= 1'b0;
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          db[i]   <= s2[i];
          cnt[i]  <= '0;
          fall[i] <= ~s2[i] & ~blk[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  logic coarse;
`ifdef KD_GAIN_COARSE_STEP_EN
  logic [1:0] cs;
  always_ff @(posedge clk) begin
    if (reset) cs <= '0;
    else       cs <= {cs[0], step_coarse};
  end
  assign coarse = cs[1];
`else
  assign coarse = 1'b0;
`endif

  logic [16:0] stp, up, dn;
  logic [15:0] inc_val, dec_val, rep_val;
  logic        act;

  assign stp     = coarse ? COARSE : FINE;
  assign up      = {1'b0, gain_out} + stp;
  assign dn      = {1'b0, gain_out} - stp;
  assign inc_val = (up > G_MAX) ? G_MAX[15:0] : up[15:0];
  assign dec_val = (dn[16] || dn < G_MIN) ? G_MIN[15:0] : dn[15:0];
  assign rep_val = act ? dec_val : inc_val;

  state_t        state;
  logic [TW-1:0] timer;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      act          <= 1'b0;
      gain_out     <= G_INIT;
      gain_changed <= 1'b0;
    end else begin
      gain_changed <= 1'b0;
      unique case (state)
        IDLE: begin
          if ((fall[0] || fall[1]) && lvl == 2'b11) begin
            state        <= LOCK;
            gain_out     <= G_INIT;
            gain_changed <= G_INIT != gain_out;
          end else if (fall[0] && !lvl[1]) begin
            state        <= DELAY;
            act          <= 1'b0;
            timer        <= T_DELAY;
            gain_out     <= inc_val;
            gain_changed <= inc_val != gain_out;
          end else if (fall[1] && !lvl[0]) begin
            state        <= DELAY;
            act          <= 1'b1;
            timer        <= T_DELAY;
            gain_out     <= dec_val;
            gain_changed <= dec_val != gain_out;
          end
        end
        DELAY, REPEAT: begin
          if (!lvl[act]) begin
            state <= IDLE;
          end else if (lvl[~act]) begin
            state        <= LOCK;
            gain_out     <= G_INIT;
            gain_changed <= G_INIT != gain_out;
          end else if (timer == '0) begin
            state        <= REPEAT;
            timer        <= T_RATE;
            gain_out     <= rep_val;
            gain_changed <= rep_val != gain_out;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        LOCK: begin
          if (db == 2'b11) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kd_gain_adjust.sv
// tb_kd_gain_adjust: directed scenarios checked every cycle against a
// time-based behavioural model plus hand-computed literal expectations.
module tb_kd_gain_adjust;

  localparam int DBC  = 4;
  localparam int RD   = 20;
  localparam int RR   = 5;
  localparam int GI   = 100;
  localparam int GMIN = 98;
  localparam int GMAX = 105;

  logic        clk;
  logic        reset;
  logic        btn_inc_n;
  logic        btn_dec_n;
  logic [15:0] gain_out;
  logic        gain_changed;

  int total = 0;
  int bad   = 0;

  kd_gain_adjust #(
    .DEBOUNCE_CYCLES(DBC),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR),
    .GAIN_INIT(GI),
    .GAIN_MIN(GMIN),
    .GAIN_MAX(GMAX),
    .STEP(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_inc_n(btn_inc_n),
    .btn_dec_n(btn_dec_n),
`ifdef KD_GAIN_COARSE_STEP_EN
    .step_coarse(1'b0),
`endif
    .gain_out(gain_out),
    .gain_changed(gain_changed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, got, want, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: sync pipe, window debounce, hold-time stepping
  int  gain_m, mode, held, prev;
  bit  chg_m, act, v1, v2, started, all_diff;
  bit  rin[2], db_m[2], fall_m[2], blk_m[2], s1_m[2], s2_m[2];
  bit  odb[2], ofall[2], oblk[2], lv[2];
  bit  win[2][DBC];
  int  nwin[2];

  function automatic int stepf(input int g, input bit down);
    if (!down) return (g + 1 > GMAX) ? GMAX : g + 1;
    return (g - 1 < GMIN) ? GMIN : g - 1;
  endfunction

  always @(posedge clk) begin
    rin[0] = btn_inc_n;
    rin[1] = btn_dec_n;
    if (reset) begin
      gain_m  = GI;
      chg_m   = 1'b0;
      mode    = 0;
      held    = 0;
      act     = 1'b0;
      v1      = 1'b0;
      v2      = 1'b0;
      started = 1'b1;
      for (int i = 0; i < 2; i++) begin
        db_m[i]   = 1'b1;
        fall_m[i] = 1'b0;
        blk_m[i]  = 1'b1;
        s1_m[i]   = 1'b1;
        s2_m[i]   = 1'b1;
        nwin[i]   = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        odb[i]   = db_m[i];
        ofall[i] = fall_m[i];
        oblk[i]  = blk_m[i];
        lv[i]    = !odb[i] && !oblk[i];
      end
      prev = gain_m;
      case (mode)
        0: begin
          if ((ofall[0] || ofall[1]) && lv[0] && lv[1]) begin
            mode   = 2;
            gain_m = GI;
          end else if (ofall[0] && !lv[1]) begin
            act = 1'b0; held = 0; mode = 1;
            gain_m = stepf(gain_m, 1'b0);
          end else if (ofall[1] && !lv[0]) begin
            act = 1'b1; held = 0; mode = 1;
            gain_m = stepf(gain_m, 1'b1);
          end
        end
        1: begin
          held++;
          if (!lv[act]) begin
            mode = 0;
          end else if (lv[!act]) begin
            mode   = 2;
            gain_m = GI;
          end else if (held == RD ||
                       (held > RD && (held - RD) % RR == 0)) begin
            gain_m = stepf(gain_m, act);
          end
        end
        default: begin
          if (odb[0] && odb[1]) mode = 0;
        end
      endcase
      chg_m = (gain_m != prev);
      for (int i = 0; i < 2; i++) begin
        for (int j = DBC - 1; j > 0; j--) win[i][j] = win[i][j-1];
        win[i][0] = s2_m[i];
        if (nwin[i] < DBC) nwin[i]++;
        fall_m[i] = 1'b0;
        if (v2 && s2_m[i] && odb[i]) blk_m[i] = 1'b0;
        all_diff = (nwin[i] == DBC);
        for (int j = 0; j < DBC; j++)
          if (win[i][j] == odb[i]) all_diff = 1'b0;
        if (all_diff) begin
          db_m[i]   = !odb[i];
          fall_m[i] = odb[i] && !oblk[i];
        end
        s2_m[i] = s1_m[i];
        s1_m[i] = rin[i];
      end
      v2 = v1;
      v1 = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("model_gain", int'(gain_out), gain_m);
      check("model_changed", int'(gain_changed), int'(chg_m));
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(5);
  endtask

  initial begin
    reset     = 1'b1;
    btn_inc_n = 1'b1;
    btn_dec_n = 1'b1;
    started   = 1'b0;

    // reset state
    tick(3);
    check("reset_gain", int'(gain_out), 100);
    check("reset_changed", int'(gain_changed), 0);
    reset = 1'b0;
    tick(10);

    // single clean inc press: 7-cycle latency
    btn_inc_n = 1'b0;
    tick(6);
    check("inc_before_latency", int'(gain_out), 100);
    tick(1);
    check("inc_at_latency", int'(gain_out), 101);
    check("inc_pulse", int'(gain_changed), 1);
    tick(3);
    btn_inc_n = 1'b1;
    tick(20);
    check("inc_settled", int'(gain_out), 101);

    // bouncing dec then a clean press
    do_reset();
    for (int k = 0; k < 6; k++) begin
      btn_dec_n = ~btn_dec_n;
      tick(2);
    end
    check("bounce_no_step", int'(gain_out), 100);
    btn_dec_n = 1'b0;
    tick(8);
    btn_dec_n = 1'b1;
    tick(15);
    check("bounce_one_dec", int'(gain_out), 99);

    // inc held: auto-repeat and clamp at max
    do_reset();
    btn_inc_n = 1'b0;
    tick(7);
    check("hold_first", int'(gain_out), 101);
    tick(20);
    check("hold_delay_step", int'(gain_out), 102);
    tick(33);
    check("hold_clamp_max", int'(gain_out), 105);
    btn_inc_n = 1'b1;
    tick(15);

    // dec clamp at min, no wrap
    do_reset();
    btn_dec_n = 1'b0;
    tick(10);
    btn_dec_n = 1'b1;
    tick(15);
    check("dec_to_99", int'(gain_out), 99);
    btn_dec_n = 1'b0;
    tick(60);
    check("dec_clamp_min", int'(gain_out), 98);
    btn_dec_n = 1'b1;
    tick(15);

    // other button during repeat -> restore and lock
    do_reset();
    btn_inc_n = 1'b0;
    tick(29);
    check("lock_pre_repeat", int'(gain_out), 102);
    btn_dec_n = 1'b0;
    tick(6);
    check("lock_last_step", int'(gain_out), 103);
    tick(1);
    check("lock_restore", int'(gain_out), 100);
    check("lock_pulse", int'(gain_changed), 1);
    tick(30);
    btn_inc_n = 1'b1;
    tick(15);
    check("lock_hold", int'(gain_out), 100);
    btn_dec_n = 1'b1;
    tick(15);
    btn_inc_n = 1'b0;
    tick(10);
    btn_inc_n = 1'b1;
    tick(15);
    check("lock_exit_inc", int'(gain_out), 101);

    // reset mid-repeat with inc still held
    do_reset();
    btn_inc_n = 1'b0;
    tick(30);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(40);
    check("held_after_reset", int'(gain_out), 100);
    btn_inc_n = 1'b1;
    tick(15);
    check("release_after_reset", int'(gain_out), 100);
    btn_inc_n = 1'b0;
    tick(10);
    btn_inc_n = 1'b1;
    tick(15);
    check("repress_after_reset", int'(gain_out), 101);

    // simultaneous press in IDLE -> restore only
    btn_inc_n = 1'b0;
    btn_dec_n = 1'b0;
    tick(10);
    check("dual_restore", int'(gain_out), 100);
    btn_inc_n = 1'b1;
    btn_dec_n = 1'b1;
    tick(15);
    btn_dec_n = 1'b0;
    tick(10);
    btn_dec_n = 1'b1;
    tick(15);
    check("dual_then_dec", int'(gain_out), 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kd_gain_adjust.md
Name: kd_gain_adjust

Overview:
- Operator-facing gain setter for the PID derivative gain (Kd).
- Turns two raw active-low board pushbuttons (increment/decrement) into a saturated 16-bit gain value, with debounce and hold-to-auto-repeat.
- gain_out drives the 16-bit input port of the Kd PIO peripheral; firmware polls that port over Avalon.
- Block sits directly upstream of that PIO, in the same clock domain.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable synchronized samples required to accept a button level change.
- REPEAT_DELAY, 25000000: cycles a single button must be held after the first step before auto-repeat starts.
- REPEAT_RATE, 5000000: cycles between auto-repeat steps.
- GAIN_INIT, 100: gain value after reset and after a dual-press restore.
- GAIN_MIN, 0: lower saturation bound.
- GAIN_MAX, 65535: upper saturation bound.
- STEP, 1: fine step size.

Ports:
- clk  input  1  system clock; only clock.
- reset  input  1  synchronous, active-high reset.
- btn_inc_n  input  1  raw asynchronous increment button, active-low.
- btn_dec_n  input  1  raw asynchronous decrement button, active-low.
- gain_out  output  16  current Kd gain; connects to the PIO in_port.
- gain_changed  output  1  one-cycle pulse on every cycle gain_out changes value.

Behaviour:
- Reset: all state sampled on rising clk while reset=1.
  - gain_out=GAIN_INIT, gain_changed=0, FSM=IDLE.
  - Synchronizers and debounced levels preset to released (1); debounce counters=0.
  - Reset mid-hold or mid-repeat aborts with no further step.
  - A button still held when reset deasserts does not generate a press until it is released and pressed again.
- Input path: 2-flop synchronizer per button, then per-button debounce counter.
  - Counter increments while synced level differs from debounced level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level flips and the counter clears.
  - Press event = debounced falling edge. Release = debounced rising edge.
- Step latency: gain_out updates exactly 2+DEBOUNCE_CYCLES+1 cycles after a clean raw edge. gain_changed asserts in the same cycle.
- Arithmetic: computed in 17 bits. inc: min(gain+STEP, GAIN_MAX). dec: max(gain-STEP, GAIN_MIN), with no unsigned wrap.
  - gain_changed=0 when a step is clamped to an unchanged value.
- FSM states: IDLE, DELAY, REPEAT, LOCK.
  - IDLE: press of exactly one button (other debounced released) -> apply one step, load timer=REPEAT_DELAY-1, go DELAY.
  - IDLE: both debounced pressed in the same cycle -> go LOCK.
  - DELAY: timer decrements each cycle.
    - Active button released -> IDLE.
    - Other button pressed -> restore GAIN_INIT, go LOCK.
    - Timer reaches 0 -> apply step, load timer=REPEAT_RATE-1, go REPEAT.
  - REPEAT: same release and other-button rules as DELAY. Timer reaches 0 -> apply step and reload REPEAT_RATE-1.
  - LOCK: entry cycle sets gain_out=GAIN_INIT. gain_changed pulses only if the value differs.
    - No steps while in LOCK.
    - Exit to IDLE only when both buttons are debounced released.
- Simultaneous debounced press of both in IDLE: no step, only the restore.
- gain_out is registered and glitch-free, and holds steady between steps.
- Parameter constraints: GAIN_MIN ≤ GAIN_INIT ≤ GAIN_MAX.

Optional Feature:
- Macro KD_GAIN_COARSE_STEP_EN.
- Defined:
  - Adds input port step_coarse (1 bit, level, synchronized by 2 flops, not debounced).
  - When step_coarse=1 at the step cycle, the step size is STEP*16. Saturation rules are unchanged.
- Undefined: port absent; step size is always STEP.

Test Plan:
- Bench parameters for all cases: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5, GAIN_INIT=100, GAIN_MIN=98, GAIN_MAX=105.
- Reset held 3 cycles, buttons released -> gain_out=100, gain_changed=0 throughout.
- Single clean btn_inc_n press held 10 cycles, then released -> gain_out=101 exactly 7 cycles after the raw edge; one gain_changed pulse; no further change.
- btn_dec_n bouncing (toggles every 2 cycles for 12 cycles), then stable low for 8 cycles, then released -> exactly one decrement to 99; one gain_changed pulse.
- btn_inc_n held 60 cycles from 100 -> steps at first-press cycle T, then T+20, T+25, T+30, T+35 (101..105). Later repeat ticks are clamped at 105 with no gain_changed.
- Dec held at 99 from the previous state -> clamps at 98, never wraps to 65535.
- Inc held into the REPEAT state, then dec pressed -> gain_out=100 with a gain_changed pulse; no steps until both are released; a subsequent single inc press -> 101.
- Reset asserted mid-REPEAT while inc is still held -> gain_out=100; no steps until inc is released and pressed again.
